array_max_scanner: RTL and testbench

- Memory-initiator engine that drives the data-memory port from the opposite side: it issues reads and writes; the data memory responds.
- On a start pulse it reads COUNT consecutive 32-bit words from a byte base address and tracks the signed maximum and its index.
- It then writes the maximum and the index to two consecutive result words.
- Sits beside the CPU datapath and shares the data-memory port through an external mux selected by busy.

---
 rtl/mem_if_pkg.sv | 17 +
 rtl/max_tracker.sv | 35 +++
 rtl/array_max_scanner.sv | 119 +++++++++++
 tb/tb_array_max_scanner.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for data-memory initiators and the CPU-side port mux.
// Holds the scanner state type, the word size in bytes and the default bus widths.
package mem_if_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WR_MAX = 3'd2,
        ST_WR_IDX = 3'd3,
        ST_DONE   = 3'd4
    } scan_state_e;

endpackage

// File: rtl/max_tracker.sv
// Registered running maximum (signed) with the index where it was found.
// first loads unconditionally; later samples replace only when strictly greater.
module max_tracker
    import mem_if_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic              first,
    input  logic [DATA_W-1:0] value,
    input  logic [CNT_W-1:0]  index,
    output logic [DATA_W-1:0] max_val,
    output logic [CNT_W-1:0]  max_idx
);

    logic take;

    // Strict compare keeps the first occurrence on ties.
    assign take = en && (first || ($signed(value) > $signed(max_val)));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (take) begin
            max_val <= value;
            max_idx <= index;
        end
    end

endmodule

// File: rtl/array_max_scanner.sv
// Memory-initiator engine: scans COUNT words from base_addr for the signed maximum,
// then writes the maximum and its index to result_addr and result_addr+4.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | waiting for start; port released (busy=0)
// ST_READ   | one element read per cycle at base+4*i
// ST_WR_MAX | write max_val to result_addr
// ST_WR_IDX | write zero-extended max_idx to result_addr+4
// ST_DONE   | one-cycle done pulse, then back to idle
module array_max_scanner
    import mem_if_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] result_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_val,
    output logic [CNT_W-1:0]  max_idx,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Write_Data,
    output logic              Mem_Read,
    output logic              Mem_Write,
    input  logic [DATA_W-1:0] Read_Data
);

    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(WORD_BYTES);

    scan_state_e       state, state_nxt;
    logic [ADDR_W-1:0] base_q, res_q;
    logic [CNT_W-1:0]  last_q, idx_q;
    logic              accept;

    assign accept = (state == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            base_q <= '0;
            res_q  <= '0;
            last_q <= '0;
            idx_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                base_q <= base_addr & WORD_MASK;
                res_q  <= result_addr & WORD_MASK;
                last_q <= count - CNT_W'(1);
                idx_q  <= '0;
            end else if (state == ST_READ) begin
                idx_q  <= idx_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = (count == '0) ? ST_DONE : ST_READ;
            ST_READ:   if (idx_q == last_q) state_nxt = ST_WR_MAX;
            ST_WR_MAX: state_nxt = ST_WR_IDX;
            ST_WR_IDX: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Port outputs depend only on registered state so they are stable for the whole cycle.
    always_comb begin
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        Mem_Read   = 1'b0;
        Mem_Write  = 1'b0;
        Address    = '0;
        Write_Data = '0;
        unique case (state)
            ST_READ: begin
                Mem_Read = 1'b1;
                Address  = base_q + ADDR_W'(idx_q) * WORD_STEP;
            end
            ST_WR_MAX: begin
                Mem_Write  = 1'b1;
                Address    = res_q;
                Write_Data = max_val;
            end
            ST_WR_IDX: begin
                Mem_Write  = 1'b1;
                Address    = res_q + WORD_STEP;
                Write_Data = DATA_W'(max_idx);
            end
            default: ;
        endcase
    end

    max_tracker #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_max_tracker (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .en      (state == ST_READ),
        .first   (idx_q == '0),
        .value   (Read_Data),
        .index   (idx_q),
        .max_val (max_val),
        .max_idx (max_idx)
    );

endmodule

// File: tb/tb_array_max_scanner.sv
// Scoreboarded bench for array_max_scanner: a small word memory answers the DUT,
// expected reads/writes/results are queued at issue time and checked by a monitor.
module tb_array_max_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] count = '0;
    logic [31:0] result_addr = '0;
    logic        busy, done, Mem_Read, Mem_Write;
    logic [31:0] max_val, Address, Write_Data, Read_Data;
    logic [15:0] max_idx;

    logic [31:0] mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        logic [31:0] mx;
        logic [15:0] idx;
        int          done_cyc;
        string       name;
    } res_t;

    logic [31:0] rd_q [$];
    wr_t         wr_q [$];
    res_t        res_q [$];
    logic [31:0] vals [$];
    logic [31:0] m_rd;
    wr_t         m_wr;
    res_t        m_res;

    array_max_scanner dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .count       (count),
        .result_addr (result_addr),
        .busy        (busy),
        .done        (done),
        .max_val     (max_val),
        .max_idx     (max_idx),
        .Address     (Address),
        .Write_Data  (Write_Data),
        .Mem_Read    (Mem_Read),
        .Mem_Write   (Mem_Write),
        .Read_Data   (Read_Data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (Mem_Write) mem[Address[11:2]] <= Write_Data;
        if (pl_en) mem[pl_addr] <= pl_data;
    end

    assign Read_Data = mem[Address[11:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %h, required no such event", name, act);
    endtask

    // Monitor: every strobe or done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (Mem_Read && Mem_Write) fail("read_and_write_same_cycle", Address);
            if (Mem_Read) begin
                if (rd_q.size() == 0) fail("unexpected_read", Address);
                else begin
                    m_rd = rd_q.pop_front();
                    chk("read_addr", Address, m_rd);
                end
            end
            if (Mem_Write) begin
                if (wr_q.size() == 0) fail("unexpected_write", Address);
                else begin
                    m_wr = wr_q.pop_front();
                    chk("write_addr", Address, m_wr.addr);
                    chk("write_data", Write_Data, m_wr.data);
                end
            end
            if (done) begin
                if (res_q.size() == 0) fail("unexpected_done", 32'(cyc));
                else begin
                    m_res = res_q.pop_front();
                    chk({m_res.name, " done_cycle"}, 32'(cyc), 32'(m_res.done_cyc));
                    chk({m_res.name, " max_val"}, max_val, m_res.mx);
                    chk({m_res.name, " max_idx"}, 32'(max_idx), 32'(m_res.idx));
                end
            end
        end
    end

    // Reference model: plain scan over the element list, signed, first occurrence wins.
    task automatic issue_scan(input string name, input logic [31:0] base,
                              input logic [31:0] res, input int hold);
        logic [31:0] b, r, a, mx;
        int          mi, n, t;
        b  = base & ~32'h3;
        r  = res & ~32'h3;
        n  = vals.size();
        mx = '0;
        mi = 0;
        for (int i = 0; i < n; i++) begin
            a = b + 32'(4 * i);
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = a[11:2];
            pl_data = vals[i];
            if (i == 0 || $signed(vals[i]) > $signed(mx)) begin
                mx = vals[i];
                mi = i;
            end
            rd_q.push_back(a);
        end
        if (n > 0) begin
            wr_q.push_back('{r, mx});
            wr_q.push_back('{r + 32'd4, 32'(mi)});
        end
        @(negedge clk);
        pl_en       = 1'b0;
        start       = 1'b1;
        base_addr   = base;
        count       = 16'(n);
        result_addr = res;
        t = cyc + 1;
        res_q.push_back('{mx, 16'(mi), t + ((n == 0) ? 0 : n + 2), name});
        repeat (hold) begin
            @(negedge clk);
            base_addr   = $urandom;
            count       = 16'($urandom_range(1, 50));
            result_addr = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_scan(input string name, input logic [31:0] exp_max, input logic [15:0] exp_idx);
        int k;
        k = 0;
        while (res_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        if (res_q.size() != 0) fail({name, " timeout_no_done"}, 32'(k));
        if (rd_q.size() != 0) fail({name, " missing_reads"}, 32'(rd_q.size()));
        if (wr_q.size() != 0) fail({name, " missing_writes"}, 32'(wr_q.size()));
        rd_q.delete();
        wr_q.delete();
        res_q.delete();
        repeat (3) @(negedge clk);
        chk({name, " busy_after"}, 32'(busy), 32'd0);
        chk({name, " hold_max"}, max_val, exp_max);
        chk({name, " hold_idx"}, 32'(max_idx), 32'(exp_idx));
    endtask

    task automatic model_max(output logic [31:0] mx, output logic [15:0] mi);
        mx = '0;
        mi = '0;
        for (int i = 0; i < vals.size(); i++)
            if (i == 0 || $signed(vals[i]) > $signed(mx)) begin
                mx = vals[i];
                mi = 16'(i);
            end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got simulation time limit, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] mx;
        logic [15:0] mi;
        logic [31:0] v;

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset max_val", max_val, 32'd0);
        chk("reset max_idx", 32'(max_idx), 32'd0);
        chk("reset Mem_Read", 32'(Mem_Read), 32'd0);
        chk("reset Mem_Write", 32'(Mem_Write), 32'd0);
        chk("reset Address", Address, 32'd0);
        chk("reset Write_Data", Write_Data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        vals = {32'd5, 32'hFFFF_FFFD, 32'd17, 32'd17, 32'd2};
        issue_scan("basic", 32'd1000, 32'd2000, 0);
        wait_scan("basic", 32'd17, 16'd2);
        chk("basic mem500", mem[500], 32'd17);
        chk("basic mem501", mem[501], 32'd2);

        vals = {32'hFFFF_FFF7, 32'hFFFF_FFFC, 32'hFFFF_FFF9};
        issue_scan("negative", 32'd1200, 32'd3000, 0);
        wait_scan("negative", 32'hFFFF_FFFC, 16'd1);

        vals.delete();
        issue_scan("count0", 32'h1234_5679, 32'h0000_0ABE, 0);
        wait_scan("count0", 32'd0, 16'd0);

        vals = {32'd3, 32'd40, 32'hFFFF_FF00, 32'd40};
        issue_scan("held_start", 32'd1600, 32'd3200, 5);
        wait_scan("held_start", 32'd40, 16'd1);

        // Abort in the third READ cycle, then confirm the old results survive.
        vals = {32'd1, 32'd2, 32'd3, 32'd99, 32'd4};
        issue_scan("reset_scan", 32'd1000, 32'd2000, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd_q.delete();
        wr_q.delete();
        res_q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst Mem_Read", 32'(Mem_Read), 32'd0);
        chk("midrst Mem_Write", 32'(Mem_Write), 32'd0);
        chk("midrst max_val", max_val, 32'd0);
        repeat (2) @(negedge clk);
        chk("midrst mem500", mem[500], 32'd17);
        chk("midrst mem501", mem[501], 32'd2);

        vals = {32'd5, 32'hFFFF_FFFD, 32'd17, 32'd17, 32'd2};
        issue_scan("after_reset", 32'd1000, 32'd2000, 0);
        wait_scan("after_reset", 32'd17, 16'd2);

        vals = {32'd7, 32'd8, 32'd6};
        issue_scan("wrap", 32'hFFFF_FFF8, 32'd2400, 0);
        wait_scan("wrap", 32'd8, 16'd1);

        vals = {32'h8000_0000};
        issue_scan("count1", 32'd400, 32'd800, 0);
        wait_scan("count1", 32'h8000_0000, 16'd0);

        for (int s = 0; s < 12; s++) begin
            vals.delete();
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
                if ($urandom_range(0, 1) == 1) v = 32'($urandom_range(0, 7)) - 32'd4;
                else v = $urandom;
                vals.push_back(v);
            end
            model_max(mx, mi);
            issue_scan("random", $urandom, $urandom, $urandom_range(0, 2));
            wait_scan("random", mx, mi);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
